// File: rtl/rx_packet_builder_pkg.sv
// rx_packet_builder_pkg: packet geometry, header field layout and FSM encodings shared by the RX builder and TX readers.
package rx_packet_builder_pkg;

    localparam int PKT_WORDS = 256;
    localparam int HDR_WORDS = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_PAY_I = 3'd2,
        ST_PAY_Q = 3'd3,
        ST_DONE  = 3'd4
    } rx_state_e;

    function automatic logic [15:0] hdr_word0(input logic ovf, input logic [8:0] len_bytes);
        return {3'b0, ovf, 3'b0, len_bytes};
    endfunction

    function automatic logic [15:0] hdr_word1(input logic [5:0] rssi6, input logic [4:0] seq, input logic [4:0] chan);
        return {rssi6, seq, chan};
    endfunction

endpackage

// File: rtl/rx_packet_builder.sv
// rx_packet_builder: frames FIFO I/Q pairs into fixed 256-word packets (4 header words + payload) for the packet RAM.
module rx_packet_builder
    import rx_packet_builder_pkg::*;
#(
    parameter logic [4:0] CHANNEL         = 5'd0,
    parameter int         PAYLOAD_SAMPLES = 126
) (
    input  logic        rxclk,
    input  logic        reset,
    input  logic [31:0] sample_data,
    input  logic [8:0]  sample_count,
    output logic        sample_rd,
    input  logic [31:0] timestamp_clock,
    input  logic        overrun,
    input  logic [31:0] rssi,
    input  logic        have_space,
    output logic [15:0] rx_databus,
    output logic        rx_WR,
    output logic        rx_WR_done,
    output logic [2:0]  state
);

    localparam logic [8:0] LEN_BYTES = 9'(PAYLOAD_SAMPLES * 4);
    localparam logic [8:0] MIN_COUNT = 9'(PAYLOAD_SAMPLES);
    localparam logic [7:0] LAST_PAIR = 8'(PAYLOAD_SAMPLES - 1);

    rx_state_e   state_q, state_d;
    logic [1:0]  hdr_cnt_q, hdr_cnt_d;
    logic [7:0]  pair_cnt_q, pair_cnt_d;
    logic [4:0]  seq_q, seq_d;
    logic        sticky_q, sticky_d;
    logic [31:0] ts_q, ts_d;
    logic [5:0]  rssi_q, rssi_d;
    logic [15:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic        done_q, done_d;
    logic        rd_q, rd_d;
    logic        start;
    logic        unused_rssi;

    assign unused_rssi = ^rssi[31:6];
    assign start       = (state_q == ST_IDLE) && (sample_count >= MIN_COUNT) && have_space;

    // Outputs are registered one step ahead: the state names the word being loaded into rx_databus.
    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        pair_cnt_d = pair_cnt_q;
        seq_d      = seq_q;
        sticky_d   = sticky_q | overrun;
        ts_d       = ts_q;
        rssi_d     = rssi_q;
        data_d     = data_q;
        wr_d       = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d    = ST_HDR;
                hdr_cnt_d  = 2'd1;
                pair_cnt_d = 8'd0;
                ts_d       = timestamp_clock;
                rssi_d     = rssi[5:0];
                sticky_d   = 1'b0;
                wr_d       = 1'b1;
                data_d     = hdr_word0(sticky_q | overrun, LEN_BYTES);
            end
            ST_HDR: begin
                wr_d      = 1'b1;
                hdr_cnt_d = hdr_cnt_q + 2'd1;
                data_d    = (hdr_cnt_q == 2'd1) ? hdr_word1(rssi_q, seq_q, CHANNEL) :
                            (hdr_cnt_q == 2'd2) ? ts_q[15:0] : ts_q[31:16];
                state_d   = (hdr_cnt_q == 2'd3) ? ST_PAY_I : ST_HDR;
            end
            ST_PAY_I: begin
                wr_d    = 1'b1;
                data_d  = sample_data[31:16];
                state_d = ST_PAY_Q;
            end
            ST_PAY_Q: begin
                wr_d       = 1'b1;
                data_d     = sample_data[15:0];
                pair_cnt_d = pair_cnt_q + 8'd1;
                state_d    = (pair_cnt_q == LAST_PAIR) ? ST_DONE : ST_PAY_I;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                seq_d   = seq_q + 5'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        rd_d = (state_d == ST_PAY_Q);
    end

    always_ff @(posedge rxclk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hdr_cnt_q  <= 2'd0;
            pair_cnt_q <= 8'd0;
            seq_q      <= 5'd0;
            sticky_q   <= 1'b0;
            ts_q       <= 32'd0;
            rssi_q     <= 6'd0;
            data_q     <= 16'd0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            pair_cnt_q <= pair_cnt_d;
            seq_q      <= seq_d;
            sticky_q   <= sticky_d;
            ts_q       <= ts_d;
            rssi_q     <= rssi_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            done_q     <= done_d;
            rd_q       <= rd_d;
        end
    end

    assign sample_rd  = rd_q;
    assign rx_databus = data_q;
    assign rx_WR      = wr_q;
    assign rx_WR_done = done_q;
    assign state      = state_q;

endmodule

// File: tb/tb_rx_packet_builder.sv
// tb_rx_packet_builder: directed checks of packet framing, header fields, overrun reporting, seq wrap and reset abort.
module tb_rx_packet_builder;

    logic        rxclk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] sample_data;
    logic [8:0]  sample_count = 9'd0;
    logic        sample_rd;
    logic [31:0] timestamp_clock = 32'h1234_5678;
    logic        overrun = 1'b0;
    logic [31:0] rssi = 32'h0000_002A;
    logic        have_space = 1'b0;
    logic [15:0] rx_databus;
    logic        rx_WR;
    logic        rx_WR_done;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;
    int rd_idx = 0;
    int base = 0;
    bit const_mode = 1'b0;
    logic [4:0] exp_seq = 5'd0;

    logic [15:0] words [256];
    int  wcnt = 0, run = 0, last_run = 0, rdc = 0, done_total = 0, wr_total = 0, rd_bad = 0;
    bit  prev_wr = 1'b0;

    rx_packet_builder #(.CHANNEL(5'd19), .PAYLOAD_SAMPLES(126)) dut (
        .rxclk(rxclk), .reset(reset), .sample_data(sample_data), .sample_count(sample_count),
        .sample_rd(sample_rd), .timestamp_clock(timestamp_clock), .overrun(overrun), .rssi(rssi),
        .have_space(have_space), .rx_databus(rx_databus), .rx_WR(rx_WR), .rx_WR_done(rx_WR_done),
        .state(state)
    );

    always #5 rxclk = ~rxclk;

    // Show-ahead FIFO model: pair n holds I=2n, Q=2n+1.
    always @(posedge rxclk) if (sample_rd) rd_idx <= rd_idx + 1;
    assign sample_data = const_mode ? 32'hAAAA_5555 : {16'(2 * rd_idx), 16'(2 * rd_idx + 1)};

    always @(negedge rxclk) begin
        if (rx_WR) begin
            if (!prev_wr) begin
                wcnt = 0;
                run  = 0;
                rdc  = 0;
            end
            if (wcnt < 256) words[wcnt] = rx_databus;
            wcnt++;
            run++;
            wr_total++;
        end
        if (!rx_WR && prev_wr) last_run = run;
        if (sample_rd) rdc++;
        if (sample_rd && state !== 3'd3) rd_bad++;
        if (rx_WR_done) done_total++;
        prev_wr = rx_WR;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic start_pkt(input bit ovf, input bit keep_space);
        @(negedge rxclk);
        sample_count = 9'd126;
        have_space   = 1'b1;
        overrun      = ovf;
        base         = rd_idx;
        @(negedge rxclk);
        overrun    = 1'b0;
        have_space = keep_space;
        chk("start_latency", {31'd0, rx_WR}, 32'd1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 700 && !seen; i++) begin
            @(negedge rxclk);
            seen = rx_WR_done;
        end
        #1;
        chk("done_timeout", {31'd0, seen}, 32'd1);
    endtask

    task automatic check_pkt(input bit ovf);
        chk("run_len", last_run, 256);
        chk("rd_pulses", rdc, 126);
        chk("word0", {16'd0, words[0]}, ovf ? 32'h11F8 : 32'h01F8);
        chk("word1", {16'd0, words[1]}, {16'd0, rssi[5:0], exp_seq, 5'd19});
        chk("word2", {16'd0, words[2]}, {16'd0, timestamp_clock[15:0]});
        chk("word3", {16'd0, words[3]}, {16'd0, timestamp_clock[31:16]});
        chk("pay_first_i", {16'd0, words[4]}, const_mode ? 32'hAAAA : 32'(16'(2 * base)));
        chk("pay_last_q", {16'd0, words[255]}, const_mode ? 32'h5555 : 32'(16'(2 * (base + 125) + 1)));
        exp_seq++;
    endtask

    initial begin
        int d0, w0;
        repeat (3) @(negedge rxclk);
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_wr", {31'd0, rx_WR}, 32'd0);
        chk("rst_done", {31'd0, rx_WR_done}, 32'd0);
        chk("rst_rd", {31'd0, sample_rd}, 32'd0);
        chk("rst_data", {16'd0, rx_databus}, 32'd0);
        reset = 1'b0;

        // Basic packet with full payload sweep
        d0 = done_total;
        start_pkt(1'b0, 1'b0);
        wait_done();
        check_pkt(1'b0);
        for (int k = 0; k < 252; k++)
            chk("payload", {16'd0, words[4 + k]}, 32'(16'(2 * base + k)));
        repeat (5) @(negedge rxclk);
        #1;
        chk("one_done", done_total - d0, 1);

        // Start gating: one sample short, then no space
        @(negedge rxclk);
        sample_count = 9'd125;
        have_space   = 1'b1;
        w0 = wr_total;
        repeat (10) @(negedge rxclk);
        #1;
        chk("no_wr_125", wr_total - w0, 0);
        start_pkt(1'b0, 1'b0);
        wait_done();
        check_pkt(1'b0);
        @(negedge rxclk);
        sample_count = 9'd126;
        have_space   = 1'b0;
        w0 = wr_total;
        repeat (10) @(negedge rxclk);
        #1;
        chk("no_wr_nospace", wr_total - w0, 0);
        start_pkt(1'b0, 1'b0);
        wait_done();
        check_pkt(1'b0);

        // Overrun mid-packet is reported in the next packet only
        start_pkt(1'b0, 1'b0);
        repeat (60) @(negedge rxclk);
        overrun = 1'b1;
        @(negedge rxclk);
        overrun = 1'b0;
        wait_done();
        check_pkt(1'b0);
        start_pkt(1'b0, 1'b0);
        wait_done();
        check_pkt(1'b1);
        start_pkt(1'b0, 1'b0);
        wait_done();
        check_pkt(1'b0);

        // Overrun on the start cycle lands in that packet only
        start_pkt(1'b1, 1'b0);
        wait_done();
        check_pkt(1'b1);
        start_pkt(1'b0, 1'b0);
        wait_done();
        check_pkt(1'b0);

        // 33 back-to-back packets: seq wraps, each packet stays 256 words
        start_pkt(1'b0, 1'b1);
        for (int i = 0; i < 33; i++) begin
            wait_done();
            if (i == 32) have_space = 1'b0;
            check_pkt(1'b0);
            base = rd_idx;
        end

        // Reset on payload word 100 aborts the packet and clears seq/sticky
        start_pkt(1'b0, 1'b0);
        repeat (40) @(negedge rxclk);
        overrun = 1'b1;
        @(negedge rxclk);
        overrun = 1'b0;
        for (int i = 0; i < 300 && wcnt != 105; i++) begin
            @(negedge rxclk);
            #1;
        end
        chk("reach_word100", wcnt, 105);
        reset = 1'b1;
        d0 = done_total;
        @(negedge rxclk);
        chk("abort_wr_low", {31'd0, rx_WR}, 32'd0);
        reset = 1'b0;
        repeat (300) @(negedge rxclk);
        #1;
        chk("no_done_after_abort", done_total, d0);
        exp_seq = 5'd0;
        start_pkt(1'b0, 1'b0);
        wait_done();
        check_pkt(1'b0);

        // Constant sample pattern with fresh timestamp and RSSI
        const_mode      = 1'b1;
        timestamp_clock = 32'hDEAD_BEEF;
        rssi            = 32'hFFFF_FFC5;
        start_pkt(1'b0, 1'b0);
        wait_done();
        check_pkt(1'b0);
        chk("pay_mid_i", {16'd0, words[130]}, 32'hAAAA);
        chk("pay_mid_q", {16'd0, words[131]}, 32'h5555);
        chk("word1_chan", {27'd0, words[1][4:0]}, 32'd19);

        chk("rd_outside_payq", rd_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
